// File: rtl/cnn_maxpool_3x3_s2_pkg.sv
// Shared definitions for the 3x3 / stride-2 / pad-1 float max-pool block.
// FpWidth is the IEEE-754 single-precision word width used by the CNN datapath.
package cnn_maxpool_3x3_s2_pkg;

   localparam int unsigned FpWidth = 32;

   // Role of the current input row in the vertical reduction.
   typedef enum logic [1:0] {
      RowFirst,  // row 0: seed the column buffer
      RowEven,   // even row > 0: fold into the column buffer
      RowOdd     // odd row: emit a pooled pixel, then reseed with this row
   } row_kind_e;

endpackage

// File: rtl/cnn_maxpool_3x3_s2_if.sv
// Pixel stream interface of the max-pool block.
//   valid_in / pxl_in        : input pixel stream (channel-major, raster order)
//   valid_out / pxl_out      : pooled pixel stream, one-cycle valid pulse per pixel
//   frame_done               : pulses with the last pooled pixel of the last channel
// master = pixel source / sink side, slave = the pooling block.
interface cnn_maxpool_3x3_s2_if
   import cnn_maxpool_3x3_s2_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FpWidth
) ();

   logic                  valid_in;
   logic [DATA_WIDTH-1:0] pxl_in;
   logic                  valid_out;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  frame_done;

   modport master (
      output valid_in,
      output pxl_in,
      input  valid_out,
      input  pxl_out,
      input  frame_done
   );

   modport slave (
      input  valid_in,
      input  pxl_in,
      output valid_out,
      output pxl_out,
      output frame_done
   );

endinterface

// File: rtl/cnn_maxpool_3x3_s2_fp_max.sv
// Combinational maximum of two IEEE-754 floats using an ordered integer key:
// positive values get the sign bit flipped, negative values are fully inverted,
// so an unsigned compare of the keys orders the floats (-0 sorts below +0).
//   a_i   : stored operand, returned on a tie
//   b_i   : incoming operand
//   max_o : the larger of the two
module cnn_maxpool_3x3_s2_fp_max
   import cnn_maxpool_3x3_s2_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FpWidth
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] max_o
);

   logic [DATA_WIDTH-1:0] key_a;
   logic [DATA_WIDTH-1:0] key_b;

   always_comb begin
      key_a = a_i[DATA_WIDTH-1] ? ~a_i : {1'b1, a_i[DATA_WIDTH-2:0]};
      key_b = b_i[DATA_WIDTH-1] ? ~b_i : {1'b1, b_i[DATA_WIDTH-2:0]};
      // Strict compare keeps the stored operand on ties.
      max_o = (key_b > key_a) ? b_i : a_i;
   end

endmodule

// File: rtl/cnn_maxpool_3x3_s2.sv
// 3x3, stride-2, pad-1 max pooling over a streamed float feature map.
// The window is reduced separably: horizontally with a one-pixel carry plus a
// partial max (hacc), vertically with a half-width column buffer (vbuf). Padding
// is handled by never feeding out-of-image positions into a compare.
//   clk         : single clock, rising edge
//   reset       : synchronous active-high reset
//   bus (slave) : valid_in/pxl_in in, valid_out/pxl_out/frame_done out
module cnn_maxpool_3x3_s2
   import cnn_maxpool_3x3_s2_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = FpWidth,
   parameter int unsigned IMAGE_WIDTH  = 24,
   parameter int unsigned IMAGE_HEIGHT = 24,
   parameter int unsigned CHANNEL_NUM  = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   cnn_maxpool_3x3_s2_if.slave  bus
);

   localparam int unsigned HalfW = IMAGE_WIDTH / 2;
   localparam int unsigned ColW  = $clog2(IMAGE_WIDTH);
   localparam int unsigned RowW  = $clog2(IMAGE_HEIGHT);
   localparam int unsigned ChW   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
   // IMAGE_WIDTH is even, so col >> 1 needs exactly one bit less than col.
   localparam int unsigned OxW   = ColW - 1;

   logic [ColW-1:0]       col_q, col_d;
   logic [RowW-1:0]       row_q, row_d;
   logic [ChW-1:0]        ch_q, ch_d;
   logic [DATA_WIDTH-1:0] hacc_q, hacc_d;
   logic [DATA_WIDTH-1:0] carry_q, carry_d;
   logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  frame_done_q, frame_done_d;

   // No reset: row 0 of every channel writes each entry before it is read.
   logic [DATA_WIDTH-1:0] vbuf_q [HalfW];
   logic [OxW-1:0]        ox;
   logic                  vbuf_we;
   logic [DATA_WIDTH-1:0] vbuf_wdata;
   logic [DATA_WIDTH-1:0] vbuf_rdata;

   logic [DATA_WIDTH-1:0] hcar_max;  // max(carry, pixel): left half of the window row
   logic [DATA_WIDTH-1:0] h_max;     // full 3-wide row maximum
   logic [DATA_WIDTH-1:0] v_max;     // column buffer folded with the row maximum

   logic      last_col, last_row, last_ch;
   row_kind_e row_kind;

   assign ox         = col_q[ColW-1:1];
   assign vbuf_rdata = vbuf_q[ox];

   cnn_maxpool_3x3_s2_fp_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_carry (
      .a_i   (carry_q),
      .b_i   (bus.pxl_in),
      .max_o (hcar_max)
   );

   cnn_maxpool_3x3_s2_fp_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_row (
      .a_i   (hacc_q),
      .b_i   (bus.pxl_in),
      .max_o (h_max)
   );

   cnn_maxpool_3x3_s2_fp_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_col (
      .a_i   (vbuf_rdata),
      .b_i   (h_max),
      .max_o (v_max)
   );

   always_comb begin
      last_col = (col_q == ColW'(IMAGE_WIDTH - 1));
      last_row = (row_q == RowW'(IMAGE_HEIGHT - 1));
      last_ch  = (ch_q == ChW'(CHANNEL_NUM - 1));
      if (row_q == '0) begin
         row_kind = RowFirst;
      end else if (row_q[0]) begin
         row_kind = RowOdd;
      end else begin
         row_kind = RowEven;
      end
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      ch_d         = ch_q;
      hacc_d       = hacc_q;
      carry_d      = carry_q;
      pxl_out_d    = pxl_out_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      vbuf_we      = 1'b0;
      vbuf_wdata   = h_max;

      if (bus.valid_in) begin
         // Raster position counters.
         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               row_d = '0;
               ch_d  = last_ch ? '0 : ch_q + ChW'(1);
            end else begin
               row_d = row_q + RowW'(1);
            end
         end else begin
            col_d = col_q + ColW'(1);
         end

         if (!col_q[0]) begin
            // Column 0 has no left neighbour, so the stale carry is ignored.
            hacc_d = (col_q == '0) ? bus.pxl_in : hcar_max;
         end else begin
            carry_d = bus.pxl_in;
            vbuf_we = 1'b1;
            unique case (row_kind)
               RowFirst: vbuf_wdata = h_max;
               RowEven:  vbuf_wdata = v_max;
               RowOdd: begin
                  // This row is also the top row of the next output window.
                  vbuf_wdata   = h_max;
                  pxl_out_d    = v_max;
                  valid_out_d  = 1'b1;
                  frame_done_d = last_row && last_col && last_ch;
               end
               default: vbuf_wdata = h_max;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         ch_q         <= '0;
         hacc_q       <= '0;
         carry_q      <= '0;
         pxl_out_q    <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         ch_q         <= ch_d;
         hacc_q       <= hacc_d;
         carry_q      <= carry_d;
         pxl_out_q    <= pxl_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (vbuf_we) begin
         vbuf_q[ox] <= vbuf_wdata;
      end
   end

   assign bus.pxl_out    = pxl_out_q;
   assign bus.valid_out  = valid_out_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_maxpool_3x3_s2.sv
// Directed bench for cnn_maxpool_3x3_s2 on a 4x4x4 frame.
module tb_cnn_maxpool_3x3_s2;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 4;
   localparam int unsigned IH = 4;
   localparam int unsigned CN = 4;
   localparam int PixPerCh    = IW * IH;
   localparam int PixPerFrame = CN * PixPerCh;
   localparam int OutPerCh    = PixPerCh / 4;
   localparam int OutPerFrame = CN * OutPerCh;

   localparam logic [31:0] Sign     = 32'h8000_0000;
   localparam logic [31:0] PosZero  = 32'h0000_0000;
   localparam logic [31:0] NegZero  = 32'h8000_0000;
   localparam logic [31:0] NegTwo   = 32'hC000_0000;
   localparam logic [31:0] NegThree = 32'hC040_0000;
   localparam logic [31:0] Fifty    = 32'h4248_0000;
   localparam logic [31:0] NegHund  = 32'hC2C8_0000;
   // PosInt[n] is the float encoding of n.
   localparam logic [31:0] PosInt [17] = '{
      32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
      32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000,
      32'h4120_0000, 32'h4130_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000,
      32'h4170_0000, 32'h4180_0000
   };

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   tcol = 0;
   int   trow = 0;
   int   stray_fd = 0;

   logic [DW-1:0] mon_data [$];
   logic          mon_fd   [$];
   int            mon_cyc  [$];
   int            exp_cyc  [$];
   logic [DW-1:0] fbuf [PixPerFrame];

   cnn_maxpool_3x3_s2_if #(.DATA_WIDTH(DW)) bus ();

   cnn_maxpool_3x3_s2 #(
      .DATA_WIDTH   (DW),
      .IMAGE_WIDTH  (IW),
      .IMAGE_HEIGHT (IH),
      .CHANNEL_NUM  (CN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && bus.valid_out === 1'b1) begin
         mon_data.push_back(bus.pxl_out);
         mon_fd.push_back(bus.frame_done);
         mon_cyc.push_back(cyc);
      end else if (!reset && bus.frame_done !== 1'b0) begin
         stray_fd++;
      end
   end

   function automatic logic [31:0] fkey(input logic [31:0] v);
      return v[31] ? ~v : (v ^ 32'h8000_0000);
   endfunction

   // Direct 3x3 window maximum over fbuf, skipping out-of-image taps.
   function automatic logic [31:0] ref_out(input int c, input int oy, input int ox);
      logic [31:0] best = '0;
      bit          have = 1'b0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            int y = 2 * oy + dy;
            int x = 2 * ox + dx;
            if (y >= 0 && y < IH && x >= 0 && x < IW) begin
               logic [31:0] v = fbuf[c * PixPerCh + y * IW + x];
               if (!have || fkey(v) > fkey(best)) best = v;
               have = 1'b1;
            end
         end
      end
      return best;
   endfunction

   task automatic clear_queues();
      mon_data.delete();
      mon_fd.delete();
      mon_cyc.delete();
      exp_cyc.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset        = 1'b1;
      bus.valid_in = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tcol  = 0;
      trow  = 0;
      clear_queues();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.valid_in = 1'b0;
         bus.pxl_in   = $urandom();
      end
   endtask

   // Drive one pixel after 'gap' idle cycles; record when its pooled output is due.
   task automatic send_px(input logic [DW-1:0] d, input int gap);
      idle(gap);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.pxl_in   = d;
      if (trow % 2 == 1 && tcol % 2 == 1) exp_cyc.push_back(cyc + 1);
      tcol++;
      if (tcol == IW) begin
         tcol = 0;
         trow = (trow == IH - 1) ? 0 : trow + 1;
      end
   endtask

   task automatic send_frame(input int max_gap);
      for (int i = 0; i < PixPerFrame; i++) begin
         send_px(fbuf[i], int'($urandom_range(0, max_gap)));
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < PixPerFrame; i++) begin
         logic [31:0] v;
         v        = $urandom();
         v[30:23] = 8'(120 + $urandom_range(0, 15));
         if ($urandom_range(0, 11) == 0) v[30:0] = '0;
         if (i > 0 && $urandom_range(0, 7) == 0) v = fbuf[i-1];
         fbuf[i] = v;
      end
   endtask

   task automatic test_reset();
      bus.valid_in = 1'b1;
      bus.pxl_in   = $urandom();
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.pxl_out !== '0) begin
         n_fail++;
         $display("FAIL reset pxl_out: got %h, want 00000000", bus.pxl_out);
      end
      n_checks++;
      if (bus.valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset valid_out: got %b, want 0", bus.valid_out);
      end
      n_checks++;
      if (bus.frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset frame_done: got %b, want 0", bus.frame_done);
      end
      bus.valid_in = 1'b0;
      reset        = 1'b0;
      tcol         = 0;
      trow         = 0;
      clear_queues();
   endtask

   // Ascending, negative, signed-zero and descending channels in one frame.
   task automatic test_patterns();
      logic [DW-1:0] exp_d [16];
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         fbuf[i]      = PosInt[i+1];
         fbuf[16 + i] = PosInt[i+1] | Sign;
         fbuf[32 + i] = NegThree;
         fbuf[48 + i] = PosInt[16-i];
      end
      fbuf[32] = NegZero;
      fbuf[33] = PosZero;
      fbuf[47] = NegTwo;
      exp_d = '{PosInt[6], PosInt[8], PosInt[14], PosInt[16],
                PosInt[1] | Sign, PosInt[2] | Sign, PosInt[5] | Sign, PosInt[6] | Sign,
                PosZero, PosZero, NegThree, NegTwo,
                PosInt[16], PosInt[15], PosInt[12], PosInt[11]};
      send_frame(0);
      idle(4);
      n_checks++;
      if (mon_data.size() != 16) begin
         n_fail++;
         $display("FAIL patterns count: got %0d, want 16", mon_data.size());
      end
      for (int k = 0; k < 16 && k < mon_data.size() && k < exp_cyc.size(); k++) begin
         n_checks++;
         if (mon_data[k] !== exp_d[k]) begin
            n_fail++;
            $display("FAIL patterns data[%0d]: got %h, want %h", k, mon_data[k], exp_d[k]);
         end
         n_checks++;
         if (mon_fd[k] !== (k == 15)) begin
            n_fail++;
            $display("FAIL patterns frame_done[%0d]: got %b, want %b", k, mon_fd[k], k == 15);
         end
         n_checks++;
         if (mon_cyc[k] !== exp_cyc[k]) begin
            n_fail++;
            $display("FAIL patterns latency[%0d]: got cycle %0d, want %0d", k, mon_cyc[k],
                     exp_cyc[k]);
         end
      end
      n_checks++;
      if (bus.pxl_out !== PosInt[11] || bus.valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL patterns hold: got %h/%b, want %h/0", bus.pxl_out, bus.valid_out,
                  PosInt[11]);
      end
   endtask

   // Random floats with random idle gaps, two frames against the window model.
   task automatic test_gaps();
      apply_reset();
      for (int f = 0; f < 2; f++) begin
         fill_random();
         clear_queues();
         send_frame(3);
         idle(4);
         n_checks++;
         if (mon_data.size() != OutPerFrame) begin
            n_fail++;
            $display("FAIL gaps count f%0d: got %0d, want %0d", f, mon_data.size(), OutPerFrame);
         end
         for (int k = 0; k < OutPerFrame && k < mon_data.size() && k < exp_cyc.size(); k++) begin
            logic [31:0] e;
            e = ref_out(k / OutPerCh, (k % OutPerCh) / (IW / 2), k % (IW / 2));
            n_checks++;
            if (mon_data[k] !== e) begin
               n_fail++;
               $display("FAIL gaps data f%0d[%0d]: got %h, want %h", f, k, mon_data[k], e);
            end
            n_checks++;
            if (mon_fd[k] !== (k == OutPerFrame - 1)) begin
               n_fail++;
               $display("FAIL gaps frame_done f%0d[%0d]: got %b", f, k, mon_fd[k]);
            end
            n_checks++;
            if (mon_cyc[k] !== exp_cyc[k]) begin
               n_fail++;
               $display("FAIL gaps latency f%0d[%0d]: got cycle %0d, want %0d", f, k,
                        mon_cyc[k], exp_cyc[k]);
            end
         end
      end
   endtask

   // Frame of 50.0 followed at once by a channel of -100.0.
   task automatic test_back_to_back();
      apply_reset();
      stray_fd = 0;
      for (int i = 0; i < PixPerFrame; i++) send_px(Fifty, 0);
      for (int i = 0; i < PixPerCh; i++) send_px(NegHund, 0);
      idle(4);
      n_checks++;
      if (mon_data.size() != OutPerFrame + OutPerCh) begin
         n_fail++;
         $display("FAIL b2b count: got %0d, want %0d", mon_data.size(), OutPerFrame + OutPerCh);
      end
      for (int k = 0; k < mon_data.size() && k < exp_cyc.size(); k++) begin
         logic [31:0] e;
         e = (k < OutPerFrame) ? Fifty : NegHund;
         n_checks++;
         if (mon_data[k] !== e || mon_fd[k] !== (k == OutPerFrame - 1)) begin
            n_fail++;
            $display("FAIL b2b out[%0d]: got %h/%b, want %h/%b", k, mon_data[k], mon_fd[k], e,
                     k == OutPerFrame - 1);
         end
         n_checks++;
         if (mon_cyc[k] !== exp_cyc[k]) begin
            n_fail++;
            $display("FAIL b2b latency[%0d]: got cycle %0d, want %0d", k, mon_cyc[k], exp_cyc[k]);
         end
      end
      n_checks++;
      if (stray_fd != 0) begin
         n_fail++;
         $display("FAIL b2b stray frame_done: got %0d, want 0", stray_fd);
      end
   endtask

   // Reset in channel 3 row 2 while pixels are streaming, then a clean frame.
   task automatic test_mid_reset();
      apply_reset();
      fill_random();
      for (int i = 0; i < 3 * PixPerCh + 2 * IW; i++) send_px(fbuf[i], 0);
      @(negedge clk);
      reset        = 1'b1;
      bus.valid_in = 1'b1;
      bus.pxl_in   = $urandom();
      @(negedge clk);
      bus.pxl_in = $urandom();
      @(negedge clk);
      reset        = 1'b0;
      bus.valid_in = 1'b0;
      tcol         = 0;
      trow         = 0;
      clear_queues();
      idle(6);
      n_checks++;
      if (mon_data.size() != 0) begin
         n_fail++;
         $display("FAIL midreset quiet: got %0d outputs, want 0", mon_data.size());
      end
      n_checks++;
      if (bus.pxl_out !== '0 || bus.frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset clear: got %h/%b, want 00000000/0", bus.pxl_out,
                  bus.frame_done);
      end
      fill_random();
      clear_queues();
      send_frame(2);
      idle(4);
      n_checks++;
      if (mon_data.size() != OutPerFrame) begin
         n_fail++;
         $display("FAIL midreset count: got %0d, want %0d", mon_data.size(), OutPerFrame);
      end
      for (int k = 0; k < OutPerFrame && k < mon_data.size() && k < exp_cyc.size(); k++) begin
         logic [31:0] e;
         e = ref_out(k / OutPerCh, (k % OutPerCh) / (IW / 2), k % (IW / 2));
         n_checks++;
         if (mon_data[k] !== e || mon_fd[k] !== (k == OutPerFrame - 1)) begin
            n_fail++;
            $display("FAIL midreset out[%0d]: got %h/%b, want %h/%b", k, mon_data[k], mon_fd[k],
                     e, k == OutPerFrame - 1);
         end
         n_checks++;
         if (mon_cyc[k] !== exp_cyc[k]) begin
            n_fail++;
            $display("FAIL midreset latency[%0d]: got cycle %0d, want %0d", k, mon_cyc[k],
                     exp_cyc[k]);
         end
      end
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.pxl_in   = '0;
      test_reset();
      test_patterns();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
